// File: rtl/inst_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding, reset PC
// default, instruction/entry widths and the prefetch FIFO entry layout.
package inst_fetch_unit_pkg;

  localparam int unsigned INST_W  = 32;
  localparam int unsigned PC_W    = 32;
  localparam int unsigned ENTRY_W = PC_W + INST_W;

  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] data;
  } fetch_entry_t;

  function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
    return {addr[PC_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetch_unit_fifo.sv
// Prefetch FIFO (module fetch_fifo): power-of-two depth, flush has priority,
// push into a full FIFO is legal when a pop happens in the same cycle.
module fetch_fifo
  import inst_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  logic [ENTRY_W-1:0] din,
  output logic [ENTRY_W-1:0] dout,
  output logic               full,
  output logic               empty,
  output logic [CW-1:0]      count
);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage is cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push && !flush) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: issues word fetches, tracks in-flight requests,
// discards wrong-path responses after a redirect, buffers the rest in a FIFO.
// Optional macro FETCH_BYPASS_EN forwards a response straight to decode when the FIFO is empty.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        CK_REF,
  input  logic        RST,
  input  logic        HALT,
  input  logic        REDIRECT_VALID,
  input  logic [31:0] REDIRECT_PC,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_GNT,
  input  logic        IMEM_RVALID,
  input  logic [31:0] IMEM_RDATA,
  output logic        INST_VALID,
  output logic [31:0] INST_DATA,
  output logic [31:0] INST_PC,
  input  logic        INST_READY
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int IW = CW + 1;

  fetch_state_e state, state_nxt;

  logic [31:0]   fetch_pc, fetch_pc_nxt;
  logic [31:0]   rsp_pc, rsp_pc_nxt;
  logic [CW-1:0] outstanding, outstanding_nxt;
  logic [CW-1:0] discard, discard_nxt;

  logic               grant;
  logic               rsp_ret;
  logic               rsp_accept;
  logic               bypass_hit;
  logic [IW-1:0]      inflight;

  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CW-1:0]      fifo_count;
  logic [ENTRY_W-1:0] fifo_din;
  logic [ENTRY_W-1:0] fifo_dout;
  fetch_entry_t       head;

  assign grant = IMEM_REQ && IMEM_GNT;
  // A response with nothing in flight is a leftover from before reset.
  assign rsp_ret    = IMEM_RVALID && (outstanding != '0);
  assign rsp_accept = rsp_ret && (state == ST_FETCH) && !REDIRECT_VALID;
  assign inflight   = {1'b0, fifo_count} + {1'b0, outstanding};

  // Every in-flight request already owns a FIFO slot, so a response never overflows.
  assign IMEM_REQ  = (state == ST_FETCH) && !HALT && !REDIRECT_VALID && !fifo_full &&
                     (inflight < IW'(DEPTH));
  assign IMEM_ADDR = word_align(fetch_pc);

`ifdef FETCH_BYPASS_EN
  assign bypass_hit = fifo_empty && rsp_accept && !HALT;
`else
  assign bypass_hit = 1'b0;
`endif

  assign head       = fetch_entry_t'(fifo_dout);
  assign INST_VALID = (state == ST_FETCH) && !HALT && (!fifo_empty || bypass_hit);
  assign INST_DATA  = bypass_hit ? IMEM_RDATA : head.data;
  assign INST_PC    = bypass_hit ? rsp_pc : head.pc;

  assign fifo_din  = {rsp_pc, IMEM_RDATA};
  assign fifo_push = rsp_accept && !(bypass_hit && INST_READY);
  assign fifo_pop  = INST_VALID && INST_READY && !REDIRECT_VALID && !bypass_hit;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (CK_REF),
    .rst   (RST),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (REDIRECT_VALID),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_nxt       = state;
    fetch_pc_nxt    = fetch_pc;
    rsp_pc_nxt      = rsp_pc;
    discard_nxt     = discard;
    outstanding_nxt = outstanding + CW'(grant) - CW'(rsp_ret);

    if (REDIRECT_VALID) begin
      // No grant is possible this cycle, so everything still pending is wrong-path.
      fetch_pc_nxt = word_align(REDIRECT_PC);
      rsp_pc_nxt   = word_align(REDIRECT_PC);
      discard_nxt  = outstanding - CW'(rsp_ret);
      state_nxt    = (discard_nxt != '0) ? ST_DRAIN : ST_FETCH;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nxt = ST_FETCH;
        end
        ST_FETCH: begin
          if (grant)      fetch_pc_nxt = fetch_pc + 32'd4;
          if (rsp_accept) rsp_pc_nxt   = rsp_pc + 32'd4;
        end
        ST_DRAIN: begin
          if (rsp_ret) discard_nxt = discard - CW'(1);
          if (discard_nxt == '0) state_nxt = ST_FETCH;
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CK_REF) begin
    if (RST) begin
      state       <= ST_IDLE;
      fetch_pc    <= word_align(RESET_PC);
      rsp_pc      <= word_align(RESET_PC);
      outstanding <= '0;
      discard     <= '0;
    end else begin
      state       <= state_nxt;
      fetch_pc    <= fetch_pc_nxt;
      rsp_pc      <= rsp_pc_nxt;
      outstanding <= outstanding_nxt;
      discard     <= discard_nxt;
    end
  end

endmodule
